// File: rtl/d_branch_ctrl.sv
// -----------------------------------------------------------------------------
// d_branch_ctrl
//
// ID-stage branch/jump resolution controller for a MIPS-style pipeline.
// Decodes beq, bne, j, jal and jr in the ID stage. It stalls the front end
// while a needed register operand is still in flight. One cycle after the
// operands become available, it issues a registered, single-cycle redirect
// pulse.
//
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined     : the delay-slot instruction executes. o_con_flush stays 0 and
//                 the link value is pcplus4 + 4.
//   not defined : every taken redirect squashes IF/ID (o_con_flush pulses) and
//                 the link value is pcplus4.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous active-high reset
//   i_valid         ID-stage instruction valid
//   i_instr         ID-stage instruction word
//   i_addr_pcplus4  PC+4 of the ID instruction
//   i_data_rs       forwarded rs operand (instr[25:21])
//   i_data_rt       forwarded rt operand (instr[20:16])
//   i_con_rs_busy   rs value not yet available
//   i_con_rt_busy   rt value not yet available
//   o_con_jump      01 = j/jal, 10 = jr, 00 = none (pulse)
//   o_con_ifbranch  taken conditional branch (pulse)
//   o_addr_jump     j/jal target (holds between redirects)
//   o_addr_jumpr    jr target (holds between redirects)
//   o_addr_branch   branch target (holds between redirects)
//   o_con_stall     combinational: hold PC and IF/ID
//   o_con_flush     squash IF/ID (pulse)
//   o_con_link      write $31 for jal (pulse)
//   o_addr_link     value written to $31 (holds between redirects)
//   o_cnt_redirect  saturating count of taken redirects
// -----------------------------------------------------------------------------
module d_branch_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_addr_pcplus4,
    input  logic [31:0] i_data_rs,
    input  logic [31:0] i_data_rt,
    input  logic        i_con_rs_busy,
    input  logic        i_con_rt_busy,
    output logic [1:0]  o_con_jump,
    output logic        o_con_ifbranch,
    output logic [31:0] o_addr_jump,
    output logic [31:0] o_addr_jumpr,
    output logic [31:0] o_addr_branch,
    output logic        o_con_stall,
    output logic        o_con_flush,
    output logic        o_con_link,
    output logic [31:0] o_addr_link,
    output logic [15:0] o_cnt_redirect
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_BEQ  = 3'd1,
        K_BNE  = 3'd2,
        K_J    = 3'd3,
        K_JAL  = 3'd4,
        K_JR   = 3'd5
    } kind_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;

    // True while an operand this instruction depends on is still in flight.
    function automatic logic operands_blocked(input kind_t k, input logic rs_busy,
                                              input logic rt_busy);
        case (k)
            K_BEQ, K_BNE: return rs_busy | rt_busy;
            K_JR:         return rs_busy;
            default:      return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------ decode
    kind_t dec_kind;

    always_comb begin
        dec_kind = K_NONE;
        case (i_instr[31:26])
            OP_BEQ:     dec_kind = K_BEQ;
            OP_BNE:     dec_kind = K_BNE;
            OP_J:       dec_kind = K_J;
            OP_JAL:     dec_kind = K_JAL;
            OP_SPECIAL: if (i_instr[5:0] == FN_JR) dec_kind = K_JR;
            default:    dec_kind = K_NONE;
        endcase
    end

    // --------------------------------------------------------------- registers
    state_t      state_q,       state_d;
    kind_t       kind_q,        kind_d;
    logic [31:0] pc_q,          pc_d;
    logic [25:0] idx_q,         idx_d;

    logic [1:0]  con_jump_q,    con_jump_d;
    logic        ifbranch_q,    ifbranch_d;
    logic        flush_q,       flush_d;
    logic        link_q,        link_d;
    logic [31:0] addr_jump_q,   addr_jump_d;
    logic [31:0] addr_jumpr_q,  addr_jumpr_d;
    logic [31:0] addr_branch_q, addr_branch_d;
    logic [31:0] addr_link_q,   addr_link_d;
    logic [15:0] cnt_q,         cnt_d;

    // Resolution context: in IDLE the live decode is used directly, in WAIT
    // the captured instruction is used with the operands sampled this cycle.
    logic        resolve_go;
    kind_t       res_kind;
    logic [31:0] res_pc;
    logic [25:0] res_idx;
    logic        taken;
    logic [31:0] br_offset;

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        pc_d          = pc_q;
        idx_d         = idx_q;
        resolve_go    = 1'b0;
        res_kind      = kind_q;
        res_pc        = pc_q;
        res_idx       = idx_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid && (dec_kind != K_NONE)) begin
                    kind_d = dec_kind;
                    pc_d   = i_addr_pcplus4;
                    idx_d  = i_instr[25:0];
                    if (operands_blocked(dec_kind, i_con_rs_busy, i_con_rt_busy)) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_RESOLVE;
                        resolve_go = 1'b1;
                        res_kind   = dec_kind;
                        res_pc     = i_addr_pcplus4;
                        res_idx    = i_instr[25:0];
                    end
                end
            end
            S_WAIT: begin
                if (!operands_blocked(kind_q, i_con_rs_busy, i_con_rt_busy)) begin
                    state_d    = S_RESOLVE;
                    resolve_go = 1'b1;
                end
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Redirect outputs are computed on the transition into RESOLVE so they
    // appear registered, as a one-cycle pulse, during the RESOLVE cycle.
    always_comb begin
        con_jump_d    = 2'b00;
        ifbranch_d    = 1'b0;
        flush_d       = 1'b0;
        link_d        = 1'b0;
        addr_jump_d   = addr_jump_q;
        addr_jumpr_d  = addr_jumpr_q;
        addr_branch_d = addr_branch_q;
        addr_link_d   = addr_link_q;
        cnt_d         = cnt_q;
        taken         = 1'b0;
        br_offset     = {{14{res_idx[15]}}, res_idx[15:0], 2'b00};

        if (resolve_go) begin
            case (res_kind)
                K_BEQ, K_BNE: begin
                    taken = (res_kind == K_BEQ) ? (i_data_rs == i_data_rt)
                                                : (i_data_rs != i_data_rt);
                    if (taken) begin
                        ifbranch_d    = 1'b1;
                        addr_branch_d = res_pc + br_offset;
                    end
                end
                K_J, K_JAL: begin
                    taken       = 1'b1;
                    con_jump_d  = 2'b01;
                    addr_jump_d = {res_pc[31:28], res_idx, 2'b00};
                    if (res_kind == K_JAL) begin
                        link_d = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
                        addr_link_d = res_pc + 32'd4;
`else
                        addr_link_d = res_pc;
`endif
                    end
                end
                K_JR: begin
                    taken        = 1'b1;
                    con_jump_d   = 2'b10;
                    addr_jumpr_d = i_data_rs;
                end
                default: begin
                    taken = 1'b0;
                end
            endcase

            if (taken) begin
`ifdef BRANCH_DELAY_SLOT_EN
                flush_d = 1'b0;
`else
                flush_d = 1'b1;
`endif
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            kind_q        <= K_NONE;
            pc_q          <= '0;
            idx_q         <= '0;
            con_jump_q    <= '0;
            ifbranch_q    <= 1'b0;
            flush_q       <= 1'b0;
            link_q        <= 1'b0;
            addr_jump_q   <= '0;
            addr_jumpr_q  <= '0;
            addr_branch_q <= '0;
            addr_link_q   <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            pc_q          <= pc_d;
            idx_q         <= idx_d;
            con_jump_q    <= con_jump_d;
            ifbranch_q    <= ifbranch_d;
            flush_q       <= flush_d;
            link_q        <= link_d;
            addr_jump_q   <= addr_jump_d;
            addr_jumpr_q  <= addr_jumpr_d;
            addr_branch_q <= addr_branch_d;
            addr_link_q   <= addr_link_d;
            cnt_q         <= cnt_d;
        end
    end

    // ----------------------------------------------------------------- outputs
    // Stall is gated by reset so every output reads 0 while reset is asserted.
    assign o_con_stall = ~i_rst &
                         (((state_q == S_IDLE) & i_valid & (dec_kind != K_NONE)) |
                          (state_q == S_WAIT));

    assign o_con_jump     = con_jump_q;
    assign o_con_ifbranch = ifbranch_q;
    assign o_con_flush    = flush_q;
    assign o_con_link     = link_q;
    assign o_addr_jump    = addr_jump_q;
    assign o_addr_jumpr   = addr_jumpr_q;
    assign o_addr_branch  = addr_branch_q;
    assign o_addr_link    = addr_link_q;
    assign o_cnt_redirect = cnt_q;

endmodule

// File: doc/d_branch_ctrl.md
D_BRANCH_CTRL -- requirements
Module: d_branch_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is asynchronous and active-high, with ports named as follows.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
  - i_clk  in  1  rising-edge clock.
  - i_rst  in  1  asynchronous active-high reset.
  - i_valid  in  1  ID-stage instruction valid.
  - i_instr  in  32  ID-stage instruction word.
  - i_addr_pcplus4  in  32  PC+4 of the ID instruction.
  - i_data_rs  in  32  forwarded rs operand (bits 25:21).
  - i_data_rt  in  32  forwarded rt operand (bits 20:16).
  - i_con_rs_busy  in  1  rs value not yet available.
  - i_con_rt_busy  in  1  rt value not yet available.
  - o_con_jump  out  2  01 = j/jal, 10 = jr, 00 = none.
  - o_con_ifbranch  out  1  taken branch.
  - o_addr_jump  out  32  j/jal target.
  - o_addr_jumpr  out  32  jr target.
  - o_addr_branch  out  32  branch target.
  - o_con_stall  out  1  hold PC and IF/ID.
  - o_con_flush  out  1  squash IF/ID.
  - o_con_link  out  1  write $31 (jal).
  - o_addr_link  out  32  value written to $31.
  - o_cnt_redirect  out  16  count of redirects.

Function
REQ-003 Control opcodes SHALL be decoded as follows; every other instruction is ignored, and the block stays in IDLE with all control outputs 0.
  - beq: opcode 6'h04.
  - bne: opcode 6'h05.
  - j: opcode 6'h02.
  - jal: opcode 6'h03.
  - jr: opcode 6'h00 with funct 6'h08.
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESOLVE.
REQ-005 In IDLE, when i_valid is high with a control opcode, the block SHALL capture the opcode, i_addr_pcplus4 and imm/index, and then transition as follows.
  - To WAIT: when a required operand's busy flag is high. beq/bne require rs and rt; jr requires rs; j/jal require none.
  - To RESOLVE: otherwise.
REQ-006 In WAIT, the block SHALL re-sample i_data_rs/i_data_rt every cycle. It SHALL move to RESOLVE in the first cycle in which all required busy flags are low, comparing and capturing the operands in that same cycle.
REQ-007 o_con_stall SHALL be combinational and equal (IDLE & i_valid & control opcode) | WAIT. It SHALL be 0 in RESOLVE.
REQ-008 RESOLVE SHALL last exactly one cycle and then return to IDLE. i_valid is not examined in RESOLVE.
REQ-009 All redirect outputs SHALL be registered. They SHALL be nonzero only in RESOLVE, as a one-cycle pulse, giving a latency of 1 cycle from the operand-ready cycle to the redirect.
REQ-010 Target arithmetic SHALL be:
  - o_addr_jump = {pcplus4[31:28], index[25:0], 2'b00}.
  - o_addr_branch = pcplus4 + (sign-extended imm << 2), modulo 2^32 (wrap-around, no overflow flag).
  - o_addr_jumpr = captured rs.
REQ-011 In RESOLVE, o_con_jump SHALL be 01 for j/jal and 10 for jr.
REQ-012 In RESOLVE, o_con_ifbranch SHALL be 1 for beq with rs==rt and for bne with rs!=rt; a not-taken branch drives all redirect outputs 0.
REQ-013 o_con_link SHALL pulse in RESOLVE for jal only.
REQ-014 o_cnt_redirect SHALL increment by 1 on each taken RESOLVE and saturate at 16'hFFFF.
REQ-015 Target address outputs SHALL hold their last value when not in RESOLVE.

Reset
REQ-016 i_rst high SHALL immediately force state IDLE and all outputs to 0, including o_cnt_redirect, regardless of clock.
REQ-017 Reset asserted during WAIT or RESOLVE SHALL abort the pending redirect; no pulse SHALL appear after reset release.

Configuration
REQ-018 When the macro BRANCH_DELAY_SLOT_EN is defined, the block SHALL behave as follows.
  - o_con_flush stays 0.
  - o_addr_link = pcplus4 + 4 (the delay-slot instruction executes).
REQ-019 When BRANCH_DELAY_SLOT_EN is not defined, the block SHALL behave as follows.
  - o_con_flush pulses with every taken redirect in RESOLVE.
  - o_addr_link = pcplus4.

Verification
REQ-020 The bench SHALL cover at least the following directed scenarios:
  - j with instr 32'h0800_0010 and pcplus4 32'h0040_0004: 1 cycle later o_con_jump=01, o_addr_jump=32'h0000_0040, o_con_stall=1 only in the accept cycle, and o_cnt_redirect=1.
  - beq with rs=rt=5 and imm=16'hFFFF at pcplus4 32'h100: o_con_ifbranch=1 and o_addr_branch=32'hFC. With rs=5, rt=6: all outputs 0 and the counter unchanged.
  - jr with i_con_rs_busy high for 3 cycles and then rs=32'h8000_0000: o_con_stall high for 4 cycles, then o_con_jump=10 and o_addr_jumpr=32'h8000_0000 in the next cycle.
  - jal at pcplus4 32'h200: o_con_link=1 and o_addr_link=32'h204 with BRANCH_DELAY_SLOT_EN (flush 0); o_addr_link=32'h200 and flush=1 without it.
  - Reset asserted mid-WAIT on a bne: outputs 0 asynchronously, state IDLE, and no redirect after release.
  - Branch with pcplus4=32'hFFFF_FFFC and imm=16'h0002: o_addr_branch=32'h0000_0004 (wrap). Also 65536 taken jumps: o_cnt_redirect saturates at 16'hFFFF.
